joy_resolve: RTL



---
 rtl/joy_resolve_pkg.sv | 48 ++++
 rtl/joy_resolve_ch.sv | 151 +++++++++++++++
 rtl/joy_resolve.sv | 42 ++++
 3 files changed

// File: rtl/joy_resolve_pkg.sv
// joy_resolve_pkg: direction indices, mode/axis types and the rotation remap shared by joy_resolve.
// Revision: 1.0
`default_nettype none

package joy_resolve_pkg;

  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_D = 2;
  localparam int DIR_U = 3;

  typedef enum logic [1:0] {
    MODE_2WAY = 2'd0,
    MODE_4WAY = 2'd1,
    MODE_8WAY = 2'd2
  } mode_e;

  typedef enum logic {
    AXIS_H = 1'b0,
    AXIS_V = 1'b1
  } axis_e;

  localparam logic LAST_LEFT  = 1'b0;
  localparam logic LAST_RIGHT = 1'b1;
  localparam logic LAST_UP    = 1'b0;
  localparam logic LAST_DOWN  = 1'b1;

  // Counter-clockwise: right->up, up->left, left->down, down->right; clockwise is the inverse.
  function automatic logic [3:0] rotate_dirs(input logic [3:0] d, input logic ccw);
    logic [3:0] r;
    r = '0;
    if (ccw) begin
      r[DIR_U] = d[DIR_R];
      r[DIR_L] = d[DIR_U];
      r[DIR_D] = d[DIR_L];
      r[DIR_R] = d[DIR_D];
    end else begin
      r[DIR_D] = d[DIR_R];
      r[DIR_R] = d[DIR_U];
      r[DIR_U] = d[DIR_L];
      r[DIR_L] = d[DIR_D];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/joy_resolve_ch.sv
// joy_resolve_ch: one player's sync, debounce, optional rotation (JOY_RESOLVE_ROT_EN),
// last-pressed resolution, mode restriction and output register. Revision: 1.0
`default_nettype none

module joy_resolve_ch
  import joy_resolve_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       I_RESETn,
  input  logic [1:0] mode_i,
`ifdef JOY_RESOLVE_ROT_EN
  input  logic       rotate_i,
  input  logic       rot_ccw_i,
`endif
  input  logic [3:0] dir_i,
  output logic [3:0] dir_o
);

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] deb_w;
  logic [3:0] scr_w;
  logic [3:0] prev_q;
  logic       last_h_q, last_h_d;
  logic       last_v_q, last_v_d;
  axis_e      last_axis_q, last_axis_d;
  logic [3:0] out_q, out_d;

  always_ff @(posedge clk or negedge I_RESETn) begin
    if (!I_RESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dir_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bit
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      logic bit_q;
      always_ff @(posedge clk or negedge I_RESETn) begin
        if (!I_RESETn) bit_q <= 1'b0;
        else           bit_q <= sync2_q[b];
      end
      assign deb_w[b] = bit_q;
    end else begin : g_count
      logic             bit_q;
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge clk or negedge I_RESETn) begin
        if (!I_RESETn) begin
          bit_q <= 1'b0;
          cnt_q <= '0;
        end else if (sync2_q[b] != bit_q) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            bit_q <= sync2_q[b];
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
      assign deb_w[b] = bit_q;
    end
  end

`ifdef JOY_RESOLVE_ROT_EN
  assign scr_w = rotate_i ? rotate_dirs(deb_w, rot_ccw_i) : deb_w;
`else
  assign scr_w = deb_w;
`endif

  always_comb begin
    logic [3:0] rise;
    logic       h_edge, v_edge;
    logic       h_act, v_act;

    rise   = scr_w & ~prev_q;
    h_edge = rise[DIR_R] | rise[DIR_L];
    v_edge = rise[DIR_U] | rise[DIR_D];

    last_h_d = last_h_q;
    if (rise[DIR_L])      last_h_d = LAST_LEFT;
    else if (rise[DIR_R]) last_h_d = LAST_RIGHT;

    last_v_d = last_v_q;
    if (rise[DIR_U])      last_v_d = LAST_UP;
    else if (rise[DIR_D]) last_v_d = LAST_DOWN;

    last_axis_d = last_axis_q;
    if (h_edge && !v_edge)      last_axis_d = AXIS_H;
    else if (v_edge && !h_edge) last_axis_d = AXIS_V;

    // Resolution uses the freshly updated memory so a new press wins in the same cycle.
    out_d = scr_w;
    if (scr_w[DIR_R] && scr_w[DIR_L]) begin
      out_d[DIR_R] = (last_h_d == LAST_RIGHT);
      out_d[DIR_L] = (last_h_d == LAST_LEFT);
    end
    if (scr_w[DIR_U] && scr_w[DIR_D]) begin
      out_d[DIR_U] = (last_v_d == LAST_UP);
      out_d[DIR_D] = (last_v_d == LAST_DOWN);
    end

    h_act = out_d[DIR_R] | out_d[DIR_L];
    v_act = out_d[DIR_U] | out_d[DIR_D];
    case (mode_e'(mode_i))
      MODE_2WAY: begin
        out_d[DIR_U] = 1'b0;
        out_d[DIR_D] = 1'b0;
      end
      MODE_4WAY: begin
        if (h_act && v_act) begin
          if (last_axis_d == AXIS_H) begin
            out_d[DIR_U] = 1'b0;
            out_d[DIR_D] = 1'b0;
          end else begin
            out_d[DIR_R] = 1'b0;
            out_d[DIR_L] = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge I_RESETn) begin
    if (!I_RESETn) begin
      prev_q      <= '0;
      last_h_q    <= LAST_LEFT;
      last_v_q    <= LAST_UP;
      last_axis_q <= AXIS_H;
      out_q       <= '0;
    end else begin
      prev_q      <= scr_w;
      last_h_q    <= last_h_d;
      last_v_q    <= last_v_d;
      last_axis_q <= last_axis_d;
      out_q       <= out_d;
    end
  end

  assign dir_o = out_q;

endmodule

`default_nettype wire

// File: rtl/joy_resolve.sv
// joy_resolve: multi-player joystick conditioner, one joy_resolve_ch per player sharing mode.
// Optional rotation ports under JOY_RESOLVE_ROT_EN. Revision: 1.0
`default_nettype none

module joy_resolve
  import joy_resolve_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CNT_W           = 8
) (
  input  logic                     clk,
  input  logic                     I_RESETn,
  input  logic [1:0]               mode,
`ifdef JOY_RESOLVE_ROT_EN
  input  logic                     rotate,
  input  logic                     rot_ccw,
`endif
  input  logic [4*NUM_PLAYERS-1:0] in_dir,
  output logic [4*NUM_PLAYERS-1:0] out_dir
);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    joy_resolve_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk      (clk),
      .I_RESETn (I_RESETn),
      .mode_i   (mode),
`ifdef JOY_RESOLVE_ROT_EN
      .rotate_i (rotate),
      .rot_ccw_i(rot_ccw),
`endif
      .dir_i    (in_dir[4*p +: 4]),
      .dir_o    (out_dir[4*p +: 4])
    );
  end

endmodule

`default_nettype wire
